// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: 8x8 unsigned multiply sequenced over one shared external 4x4
// multiplier in four steps. Each step drives a nibble pair to the multiplier,
// and the 8-bit partial product is added to a 16-bit accumulator at weight
// 0, 4, 4 or 8.
//
// Parameters:
//   PIPE_MUL  0: add mul_p in the same cycle it is produced.
//             1: register mul_p first and add it one cycle later. This adds a
//                DRAIN state for the final partial product.
//
// Optional feature (macro MUL8_SEQ_ACCUM_EN):
//   Adds the acc_clr input, which is sampled with the operand handshake. When
//   acc_clr is 0, the new product is added to the previous accumulator value
//   (multiply-accumulate, wrapping modulo 2^16).
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake, carries a and b
//   acc_clr              accumulator clear on accept (MUL8_SEQ_ACCUM_EN only)
//   out_valid/out_ready  result handshake, carries product
//   product              registered 16-bit result
//   busy                 high whenever the controller is not idle
//   mul_m, mul_q, mul_p  connection to the shared 4x4 multiplier
module mul8_seq_ctrl #(
    parameter int unsigned PIPE_MUL = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
`ifdef MUL8_SEQ_ACCUM_EN
    input  logic        acc_clr,
`endif
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy,
    output logic [3:0]  mul_m,
    output logic [3:0]  mul_q,
    input  logic [7:0]  mul_p
);

    typedef enum logic [1:0] {StIdle, StMul, StDrain, StDone} state_t;

    state_t      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] product_q, product_d;
    logic [7:0]  p_q, p_d;
    logic [3:0]  p_sh_q, p_sh_d;

    logic [3:0]  cur_sh;
    logic [15:0] addend;
    logic [15:0] acc_sum;
    logic        clr_on_accept;

`ifdef MUL8_SEQ_ACCUM_EN
    assign clr_on_accept = acc_clr;
`else
    assign clr_on_accept = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            step_q    <= 2'd0;
            a_q       <= 8'd0;
            b_q       <= 8'd0;
            acc_q     <= 16'd0;
            product_q <= 16'd0;
            p_q       <= 8'd0;
            p_sh_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            p_q       <= p_d;
            p_sh_q    <= p_sh_d;
        end
    end

    // Weight of the partial product for each step. Steps 1 and 2 are the two
    // cross terms.
    always_comb begin
        cur_sh = 4'd0;
        unique case (step_q)
            2'd0: cur_sh = 4'd0;
            2'd1: cur_sh = 4'd4;
            2'd2: cur_sh = 4'd4;
            2'd3: cur_sh = 4'd8;
            default: cur_sh = 4'd0;
        endcase
    end

    // The nibble select depends only on registered state. This keeps mul_m and
    // mul_q free of any combinational path from the operand inputs.
    always_comb begin
        mul_m = 4'd0;
        mul_q = 4'd0;
        if (state_q == StMul) begin
            mul_m = step_q[0] ? a_q[7:4] : a_q[3:0];
            mul_q = step_q[1] ? b_q[7:4] : b_q[3:0];
        end
    end

    // In piped mode, the partial product captured in the previous cycle is
    // added using the weight that was stored with it. In step 0 there is
    // nothing captured yet to add.
    always_comb begin
        addend = 16'd0;
        if (PIPE_MUL != 0) begin
            if ((state_q == StMul && step_q != 2'd0) || state_q == StDrain) begin
                addend = {8'd0, p_q} << p_sh_q;
            end
        end else if (state_q == StMul) begin
            addend = {8'd0, mul_p} << cur_sh;
        end
    end

    assign acc_sum = acc_q + addend;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        product_d = product_q;
        p_d       = p_q;
        p_sh_d    = p_sh_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    step_d  = 2'd0;
                    acc_d   = clr_on_accept ? 16'd0 : acc_q;
                    state_d = StMul;
                end
            end
            StMul: begin
                acc_d  = acc_sum;
                p_d    = mul_p;
                p_sh_d = cur_sh;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    if (PIPE_MUL != 0) begin
                        state_d = StDrain;
                    end else begin
                        product_d = acc_sum;
                        state_d   = StDone;
                    end
                end
            end
            StDrain: begin
                acc_d     = acc_sum;
                product_d = acc_sum;
                state_d   = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign product = product_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
module tb_mul8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid  [2];
    logic        out_ready [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        busy      [2];
    logic [7:0]  a         [2];
    logic [7:0]  b         [2];
    logic [7:0]  mul_p     [2];
    logic [3:0]  mul_m     [2];
    logic [3:0]  mul_q     [2];
    logic [15:0] product   [2];
`ifdef MUL8_SEQ_ACCUM_EN
    logic        acc_clr   [2];
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int oc1, oc2, cnt;
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [15:0] model_acc [2];
    logic [3:0]  em [4];
    logic [3:0]  eq [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for the shared 4x4 multiplier.
    assign mul_p[0] = {4'd0, mul_m[0]} * {4'd0, mul_q[0]};
    assign mul_p[1] = {4'd0, mul_m[1]} * {4'd0, mul_q[1]};

    mul8_seq_ctrl #(.PIPE_MUL(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]),
`ifdef MUL8_SEQ_ACCUM_EN
        .acc_clr(acc_clr[0]),
`endif
        .in_ready(in_ready[0]), .a(a[0]), .b(b[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .product(product[0]), .busy(busy[0]),
        .mul_m(mul_m[0]), .mul_q(mul_q[0]), .mul_p(mul_p[0])
    );

    mul8_seq_ctrl #(.PIPE_MUL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]),
`ifdef MUL8_SEQ_ACCUM_EN
        .acc_clr(acc_clr[1]),
`endif
        .in_ready(in_ready[1]), .a(a[1]), .b(b[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .product(product[1]), .busy(busy[1]),
        .mul_m(mul_m[1]), .mul_q(mul_q[1]), .mul_p(mul_p[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int u, input logic [7:0] av, input logic [7:0] bv,
                            input logic clr);
        logic [15:0] p;
        p = {8'd0, av} * {8'd0, bv};
        model_acc[u] = clr ? p : model_acc[u] + p;
        if (u == 0) exp_q0.push_back(model_acc[u]);
        else        exp_q1.push_back(model_acc[u]);
    endtask

    // Called at a negedge. Returns at the negedge of cycle 1 after the handshake.
    task automatic accept(input int u, input logic [7:0] av, input logic [7:0] bv,
                          input logic clr);
        int n = 0;
        while (!in_ready[u] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("in_ready_u%0d", u), 32'(in_ready[u]), 32'd1);
        in_valid[u] = 1'b1;
        a[u] = av;
        b[u] = bv;
`ifdef MUL8_SEQ_ACCUM_EN
        acc_clr[u] = clr;
`endif
        push_exp(u, av, bv, clr);
        @(negedge clk);
        in_valid[u] = 1'b0;
    endtask

    // Waits for out_valid, with n0 being the cycle index at the time of the call.
    task automatic collect(input int u, input int n0, input int lat, output int ocyc);
        int n;
        int sz;
        logic [15:0] e;
        n = n0;
        while (!out_valid[u] && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("latency_u%0d", u), n, lat);
        chk($sformatf("out_valid_u%0d", u), 32'(out_valid[u]), 32'd1);
        sz = (u == 0) ? exp_q0.size() : exp_q1.size();
        chk($sformatf("sb_size_u%0d", u), sz, 32'd1);
        e = 16'hxxxx;
        if (sz > 0) e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk($sformatf("product_u%0d", u), 32'(product[u]), 32'(e));
        ocyc = cyc;
    endtask

    task automatic chk_idle(input int u, input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready[u]), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid[u]), 32'd0);
        chk({tag, "_busy"}, 32'(busy[u]), 32'd0);
        chk({tag, "_mul_m"}, 32'(mul_m[u]), 32'd0);
        chk({tag, "_mul_q"}, 32'(mul_q[u]), 32'd0);
    endtask

    initial begin
        in_valid  = '{1'b0, 1'b0};
        out_ready = '{1'b1, 1'b1};
        a = '{8'd0, 8'd0};
        b = '{8'd0, 8'd0};
`ifdef MUL8_SEQ_ACCUM_EN
        acc_clr = '{1'b1, 1'b1};
`endif
        model_acc = '{16'd0, 16'd0};
        em = '{4'd2, 4'd1, 4'd2, 4'd1};
        eq = '{4'd4, 4'd4, 4'd3, 4'd3};

        // Reset state.
        repeat (2) @(negedge clk);
        chk_idle(0, "rst_u0");
        chk_idle(1, "rst_u1");
        chk("rst_product_u0", 32'(product[0]), 32'd0);
        chk("rst_product_u1", 32'(product[1]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 0x12*0x34: nibble sequence, latency, and in_ready afterwards.
        accept(0, 8'h12, 8'h34, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mul_m_step%0d", k), 32'(mul_m[0]), 32'(em[k]));
            chk($sformatf("mul_q_step%0d", k), 32'(mul_q[0]), 32'(eq[k]));
            chk($sformatf("in_ready_mul%0d", k), 32'(in_ready[0]), 32'd0);
            @(negedge clk);
        end
        collect(0, 5, 5, oc1);
        @(negedge clk);
        chk("post_done_in_ready", 32'(in_ready[0]), 32'd1);

        // Corner values, back-to-back, giving one result every 6 cycles.
        accept(0, 8'hFF, 8'hFF, 1'b1);
        collect(0, 1, 5, oc1);
        @(negedge clk);
        accept(0, 8'h00, 8'hA5, 1'b1);
        collect(0, 1, 5, oc2);
        chk("throughput_u0", oc2 - oc1, 32'd6);
        @(negedge clk);

        // Backpressure: the result is held, and new operands are not taken early.
        out_ready[0] = 1'b0;
        accept(0, 8'h55, 8'h66, 1'b1);
        collect(0, 1, 5, oc1);
        for (int i = 0; i < 3; i++) begin
            in_valid[0] = 1'b1;
            a[0] = 8'h01;
            b[0] = 8'h01;
            @(negedge clk);
            chk($sformatf("bp_out_valid%0d", i), 32'(out_valid[0]), 32'd1);
            chk($sformatf("bp_product%0d", i), 32'(product[0]), 32'h21DE);
            chk($sformatf("bp_in_ready%0d", i), 32'(in_ready[0]), 32'd0);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", 32'(out_valid[0]), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready[0]), 32'd1);
        push_exp(0, 8'h01, 8'h01, 1'b1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        collect(0, 1, 5, oc1);
        @(negedge clk);

        // Reset during step 2 discards the operation.
        accept(0, 8'h12, 8'h34, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_mul_m", 32'(mul_m[0]), 32'd2);
        chk("pre_rst_mul_q", 32'(mul_q[0]), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle(0, "midrst");
        chk("midrst_product", 32'(product[0]), 32'd0);
        exp_q0.delete();
        model_acc = '{16'd0, 16'd0};
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid[0]) cnt++;
        end
        chk("midrst_no_stray_valid", cnt, 32'd0);

        // Piped variant: latency 6, one result every 7 cycles.
        accept(1, 8'hAB, 8'hCD, 1'b1);
        collect(1, 1, 6, oc1);
        @(negedge clk);
        accept(1, 8'h3C, 8'h5A, 1'b1);
        collect(1, 1, 6, oc2);
        chk("throughput_u1", oc2 - oc1, 32'd7);
        @(negedge clk);
        accept(1, 8'hFF, 8'hFF, 1'b1);
        collect(1, 1, 6, oc1);
        @(negedge clk);

`ifdef MUL8_SEQ_ACCUM_EN
        // Multiply-accumulate, including wrap modulo 2^16.
        accept(0, 8'h10, 8'h10, 1'b1);
        collect(0, 1, 5, oc1);
        @(negedge clk);
        accept(0, 8'h10, 8'h10, 1'b0);
        collect(0, 1, 5, oc1);
        @(negedge clk);
        accept(0, 8'hFF, 8'hFF, 1'b1);
        collect(0, 1, 5, oc1);
        @(negedge clk);
        accept(0, 8'hFF, 8'hFF, 1'b0);
        collect(0, 1, 5, oc1);
        @(negedge clk);
        accept(1, 8'hFF, 8'hFF, 1'b0);
        collect(1, 1, 6, oc1);
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
